// File: rtl/coin_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : coin_accumulator_if
// Purpose  : Coin/session control inputs and credit/refund outputs of the
//            coin accumulator.
// Revision : 1.0
// ============================================================================
interface coin_accumulator_if;
  logic       enable;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       lock;
  logic       clear;
  logic       refund_req;
  logic [6:0] coin_val;
  logic [3:0] coin_count;
  logic       coin_accept;
  logic       coin_reject;
  logic       refund_valid;
  logic [6:0] refund_amt;
  logic       busy;

  modport master (
    output enable, coin_valid, coin_type, lock, clear, refund_req,
    input  coin_val, coin_count, coin_accept, coin_reject,
           refund_valid, refund_amt, busy
  );

  modport slave (
    input  enable, coin_valid, coin_type, lock, clear, refund_req,
    output coin_val, coin_count, coin_accept, coin_reject,
           refund_valid, refund_amt, busy
  );
endinterface
`default_nettype wire

// File: rtl/coin_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : coin_accumulator
// Purpose  : Validates coins, keeps the running credit for one vending session
//            and releases it by consume (clear) or refund.
// Revision : 1.0
// ============================================================================
module coin_accumulator #(
  parameter int unsigned COIN0_VAL  = 5,
  parameter int unsigned COIN1_VAL  = 10,
  parameter int unsigned COIN2_VAL  = 20,
  parameter int unsigned COIN3_VAL  = 50,
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned MAX_COINS  = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  coin_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_LOCKED  = 2'd2,
    S_REFUND  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] coin_val_q, coin_val_d;
  logic [3:0] coin_count_q, coin_count_d;
  logic       coin_accept_q, coin_accept_d;
  logic       coin_reject_q, coin_reject_d;
  logic       refund_valid_q, refund_valid_d;
  logic [6:0] refund_amt_q, refund_amt_d;
  logic       busy_q, busy_d;

  logic [7:0] coin_value;
  logic [7:0] credit_sum;
  logic       coin_ok;
  logic       take_coin;

  always_comb begin
    case (bus.coin_type)
      2'b00:   coin_value = 8'(COIN0_VAL);
      2'b01:   coin_value = 8'(COIN1_VAL);
      2'b10:   coin_value = 8'(COIN2_VAL);
      default: coin_value = 8'(COIN3_VAL);
    endcase
  end

  // Sum is one bit wider than the credit so an overflowing coin cannot wrap.
  assign credit_sum = {1'b0, coin_val_q} + coin_value;
  assign coin_ok    = bus.coin_valid && bus.enable &&
                      (credit_sum <= 8'(MAX_CREDIT)) &&
                      (coin_count_q < 4'(MAX_COINS));

  always_comb begin
    state_d        = state_q;
    coin_val_d     = coin_val_q;
    coin_count_d   = coin_count_q;
    coin_accept_d  = 1'b0;
    coin_reject_d  = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = 7'd0;
    take_coin      = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_coin = coin_ok;
        if (coin_ok) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (bus.refund_req) begin
          state_d = S_REFUND;
        end else if (bus.clear) begin
          state_d      = S_IDLE;
          coin_val_d   = 7'd0;
          coin_count_d = 4'd0;
        end else if (bus.lock) begin
          state_d = S_LOCKED;
        end else if (!bus.enable) begin
          state_d = S_REFUND;
        end else begin
          take_coin = coin_ok;
        end
      end
      S_LOCKED: begin
        if (bus.refund_req) begin
          state_d = S_REFUND;
        end else if (bus.clear) begin
          state_d      = S_IDLE;
          coin_val_d   = 7'd0;
          coin_count_d = 4'd0;
        end else if (!bus.lock) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d      = S_IDLE;
        coin_val_d   = 7'd0;
        coin_count_d = 4'd0;
      end
    endcase

    if (take_coin) begin
      coin_val_d    = credit_sum[6:0];
      coin_count_d  = coin_count_q + 4'd1;
      coin_accept_d = 1'b1;
    end
    coin_reject_d = bus.coin_valid && !take_coin;

    // Credit is still held while in REFUND; it is snapshotted on the entry edge.
    if ((state_d == S_REFUND) && (state_q != S_REFUND)) begin
      refund_valid_d = 1'b1;
      refund_amt_d   = coin_val_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      coin_val_q     <= 7'd0;
      coin_count_q   <= 4'd0;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_amt_q   <= 7'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      coin_val_q     <= coin_val_d;
      coin_count_q   <= coin_count_d;
      coin_accept_q  <= coin_accept_d;
      coin_reject_q  <= coin_reject_d;
      refund_valid_q <= refund_valid_d;
      refund_amt_q   <= refund_amt_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.coin_val     = coin_val_q;
  assign bus.coin_count   = coin_count_q;
  assign bus.coin_accept  = coin_accept_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.refund_valid = refund_valid_q;
  assign bus.refund_amt   = refund_amt_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_accumulator
// Purpose  : Directed scenarios plus randomized traffic against a session model.
// Revision : 1.0
// ============================================================================
module tb_coin_accumulator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  coin_accumulator_if bus ();

  coin_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Session model: credit/coins held, plus whether the session is open,
  // frozen for dispensing, or paying out a refund this cycle.
  int m_credit, m_coins, m_ra;
  bit m_open, m_frozen, m_paying, m_acc, m_rej, m_rv;

  function automatic int coin_worth(input logic [1:0] t);
    int worth [4] = '{5, 10, 20, 50};
    return worth[t];
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_coins = 0; m_ra = 0;
    m_open = 0; m_frozen = 0; m_paying = 0;
    m_acc = 0; m_rej = 0; m_rv = 0;
  endfunction

  function automatic void model_step();
    bit start_refund, end_session, taken;
    bit can_take;
    start_refund = 0; end_session = 0; taken = 0;
    can_take = bus.enable && (m_credit + coin_worth(bus.coin_type) <= 100) && (m_coins < 15);
    m_acc = 0; m_rv = 0; m_ra = 0;
    if (m_paying) begin
      end_session = 1;
    end else if (!m_open) begin
      taken = can_take;
    end else if (bus.refund_req) begin
      start_refund = 1;
    end else if (bus.clear) begin
      end_session = 1;
    end else if (m_frozen) begin
      if (!bus.lock) m_frozen = 0;
    end else if (bus.lock) begin
      m_frozen = 1;
    end else if (!bus.enable) begin
      start_refund = 1;
    end else begin
      taken = can_take;
    end
    m_rej = bus.coin_valid && !(taken && bus.coin_valid);
    if (taken && bus.coin_valid) begin
      m_credit += coin_worth(bus.coin_type);
      m_coins  += 1;
      m_acc     = 1;
      m_open    = 1;
    end
    if (start_refund) begin
      m_rv = 1; m_ra = m_credit; m_paying = 1;
    end
    if (end_session) begin
      m_credit = 0; m_coins = 0; m_open = 0; m_frozen = 0; m_paying = 0;
    end
  endfunction

  task automatic step(input logic en, input logic cv, input logic [1:0] ct,
                      input logic lk, input logic cl, input logic rf);
    @(negedge clk);
    bus.enable = en; bus.coin_valid = cv; bus.coin_type = ct;
    bus.lock = lk; bus.clear = cl; bus.refund_req = rf;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] ct);
    step(1'b1, 1'b1, ct, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle(input logic en);
    step(en, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.enable = 0; bus.coin_valid = 0; bus.coin_type = 0;
    bus.lock = 0; bus.clear = 0; bus.refund_req = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.coin_val, bus.coin_count, bus.coin_accept, bus.coin_reject,
         bus.refund_valid, bus.refund_amt, bus.busy} !== 22'd0)
      $display("FAIL reset_outputs: got val=%0d cnt=%0d acc=%b rej=%b rv=%b ra=%0d busy=%b, want all 0",
               bus.coin_val, bus.coin_count, bus.coin_accept, bus.coin_reject,
               bus.refund_valid, bus.refund_amt, bus.busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    apply_reset();
    coin(2'b01);
    n_checks++;
    if (bus.coin_accept !== 1'b1 || bus.coin_val !== 7'd10)
      $display("FAIL basic_first: got acc=%b val=%0d, want acc=1 val=10", bus.coin_accept, bus.coin_val);
    else n_pass++;
    coin(2'b10);
    n_checks++;
    if (bus.coin_accept !== 1'b1 || bus.coin_val !== 7'd30 || bus.coin_count !== 4'd2 || bus.busy !== 1'b1)
      $display("FAIL basic_second: got acc=%b val=%0d cnt=%0d busy=%b, want 1/30/2/1",
               bus.coin_accept, bus.coin_val, bus.coin_count, bus.busy);
    else n_pass++;
  endtask

  task automatic test_max_credit();
    apply_reset();
    coin(2'b11); coin(2'b10); coin(2'b01);
    coin(2'b10);
    n_checks++;
    if (bus.coin_accept !== 1'b1 || bus.coin_val !== 7'd100)
      $display("FAIL credit_limit_fill: got acc=%b val=%0d, want acc=1 val=100", bus.coin_accept, bus.coin_val);
    else n_pass++;
    coin(2'b00);
    n_checks++;
    if (bus.coin_reject !== 1'b1 || bus.coin_accept !== 1'b0 || bus.coin_val !== 7'd100)
      $display("FAIL credit_limit_over: got rej=%b acc=%b val=%0d, want rej=1 acc=0 val=100",
               bus.coin_reject, bus.coin_accept, bus.coin_val);
    else n_pass++;
  endtask

  task automatic test_lock_clear();
    apply_reset();
    coin(2'b10); coin(2'b01); coin(2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 1), 2'b01, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bus.coin_val !== 7'd35 || bus.coin_reject !== (i == 1) || bus.coin_accept !== 1'b0)
        $display("FAIL lock_hold[%0d]: got val=%0d rej=%b acc=%b, want val=35 rej=%b acc=0",
                 i, bus.coin_val, bus.coin_reject, bus.coin_accept, (i == 1));
      else n_pass++;
    end
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.coin_val !== 7'd0 || bus.coin_count !== 4'd0 || bus.busy !== 1'b0 || bus.refund_valid !== 1'b0)
      $display("FAIL lock_clear: got val=%0d cnt=%0d busy=%b rv=%b, want 0/0/0/0",
               bus.coin_val, bus.coin_count, bus.busy, bus.refund_valid);
    else n_pass++;
  endtask

  task automatic test_refund_priority();
    apply_reset();
    coin(2'b10); coin(2'b10); coin(2'b00);
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.coin_reject !== 1'b1 || bus.refund_valid !== 1'b1 || bus.refund_amt !== 7'd45)
      $display("FAIL refund_entry: got rej=%b rv=%b ra=%0d, want rej=1 rv=1 ra=45",
               bus.coin_reject, bus.refund_valid, bus.refund_amt);
    else n_pass++;
    idle_cycle(1'b1);
    n_checks++;
    if (bus.coin_val !== 7'd0 || bus.busy !== 1'b0 || bus.refund_valid !== 1'b0 || bus.refund_amt !== 7'd0)
      $display("FAIL refund_exit: got val=%0d busy=%b rv=%b ra=%0d, want all 0",
               bus.coin_val, bus.busy, bus.refund_valid, bus.refund_amt);
    else n_pass++;
  endtask

  task automatic test_auto_refund();
    apply_reset();
    coin(2'b10);
    idle_cycle(1'b0);
    n_checks++;
    if (bus.refund_valid !== 1'b1 || bus.refund_amt !== 7'd20)
      $display("FAIL auto_refund: got rv=%b ra=%0d, want rv=1 ra=20", bus.refund_valid, bus.refund_amt);
    else n_pass++;
    idle_cycle(1'b0);
    n_checks++;
    if (bus.refund_valid !== 1'b0 || bus.refund_amt !== 7'd0 || bus.coin_val !== 7'd0)
      $display("FAIL auto_refund_pulse: got rv=%b ra=%0d val=%0d, want 0/0/0",
               bus.refund_valid, bus.refund_amt, bus.coin_val);
    else n_pass++;
  endtask

  task automatic test_max_coins();
    apply_reset();
    for (int i = 0; i < 15; i++) coin(2'b00);
    n_checks++;
    if (bus.coin_val !== 7'd75 || bus.coin_count !== 4'd15 || bus.coin_accept !== 1'b1)
      $display("FAIL coin_limit_fill: got val=%0d cnt=%0d acc=%b, want 75/15/1",
               bus.coin_val, bus.coin_count, bus.coin_accept);
    else n_pass++;
    coin(2'b00);
    n_checks++;
    if (bus.coin_reject !== 1'b1 || bus.coin_count !== 4'd15 || bus.coin_val !== 7'd75)
      $display("FAIL coin_limit_over: got rej=%b cnt=%0d val=%0d, want 1/15/75",
               bus.coin_reject, bus.coin_count, bus.coin_val);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    coin(2'b11);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.coin_val !== 7'd0 || bus.busy !== 1'b0 || bus.refund_valid !== 1'b0 || bus.coin_count !== 4'd0)
      $display("FAIL async_reset: got val=%0d busy=%b rv=%b cnt=%0d, want all 0",
               bus.coin_val, bus.busy, bus.refund_valid, bus.coin_count);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [21:0] got, want;
    int errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0));
      got  = {bus.coin_val, bus.coin_count, bus.coin_accept, bus.coin_reject,
              bus.refund_valid, bus.refund_amt, bus.busy};
      want = {7'(m_credit), 4'(m_coins), m_acc, m_rej, m_rv, 7'(m_ra), (m_open || m_paying)};
      n_checks++;
      if (got !== want) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got {val,cnt,acc,rej,rv,ra,busy}=%h, want %h", i, got, want);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    bus.enable = 0; bus.coin_valid = 0; bus.coin_type = 0;
    bus.lock = 0; bus.clear = 0; bus.refund_req = 0;
    model_reset();
    test_reset();
    test_basic();
    test_max_credit();
    test_lock_clear();
    test_refund_priority();
    test_auto_refund();
    test_max_coins();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
